// File: rtl/sensor_frame_fmt_if.sv
// Sample-in / byte-out bundle between a sensor front end, the frame formatter and a UART.
// The formatter uses the slave view; the sample source and byte sink use the master view.
interface sensor_frame_fmt_if #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 20
);
    logic                       din_vld;
    logic [NUM_CH*DATA_W-1:0]   din;
    logic                       mode;
    logic [7:0]                 tx_data;
    logic                       tx_vld;
    logic                       tx_rdy;

    modport master (
        output din_vld, din, mode, tx_rdy,
        input  tx_data, tx_vld
    );

    modport slave (
        input  din_vld, din, mode, tx_rdy,
        output tx_data, tx_vld
    );
endinterface

// File: rtl/sensor_frame_fmt.sv
// Scales raw channel samples and renders them as ASCII or binary frames into a FWFT byte FIFO.
// SCALE 1 cycle, CONV 11 cycles/channel (ASCII only), CHECK 1, EMIT 1 byte/cycle; tx_rdy only drains the FIFO, samples arriving while busy and frames that do not fit whole are dropped and counted.
module sensor_frame_fmt #(
    parameter int                NUM_CH     = 2,
    parameter int                DATA_W     = 20,
    parameter logic [NUM_CH-1:0] CH_KIND    = 2'b01,
    parameter int                FIFO_DEPTH = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    sensor_frame_fmt_if.slave             bus,
    output logic                          busy,
    output logic [7:0]                    drop_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_lvl
);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int MAX_LEN = 10 * NUM_CH + 1;
    localparam int IW      = $clog2(MAX_LEN + 1);
    localparam int FRM_N   = 1 << IW;
    localparam int BIN_LEN = 2 * NUM_CH + 3;

    function automatic int ascii_len();
        int n = NUM_CH + 1;
        for (int c = 0; c < NUM_CH; c++) n += CH_KIND[c] ? 9 : 8;
        return n;
    endfunction

    localparam int ASC_LEN = ascii_len();

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SCALE = 3'd1;
    localparam logic [2:0] S_CONV  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_EMIT  = 3'd4;

    // Full-width product before the shift, so no precision is lost.
    function automatic logic [15:0] scale(input logic [DATA_W-1:0] raw, input logic is_t);
        logic [DATA_W+10:0] p;
        p = (DATA_W+11)'(raw) * (DATA_W+11)'(is_t ? 2000 : 1000);
        p = p >> DATA_W;
        return is_t ? 16'(p) - 16'd500 : 16'(p);
    endfunction

    function automatic logic [10:0] mag(input logic [15:0] v);
        return 11'(v[15] ? 16'(-v) : v);
    endfunction

    logic [2:0]                 state_q, state_d;
    logic [NUM_CH*DATA_W-1:0]   raw_q;
    logic                       mode_q;
    logic [NUM_CH-1:0][15:0]    val_q, val_d;
    logic [NUM_CH-1:0][15:0]    dig_q;
    logic [10:0]                bin_q;
    logic [15:0]                bcd_q, bcd_adj, bcd_nxt;
    logic [3:0]                 bit_q;
    logic [CW-1:0]              ch_q, ch_nxt;
    logic [IW-1:0]              idx_q, frame_len;
    logic [FRM_N-1:0][7:0]      frm;
    logic [AW:0]                wr_ptr_q, rd_ptr_q, free;
    logic [7:0]                 mem [FIFO_DEPTH];
    logic [7:0]                 drop_q, drop_d;
    logic [8:0]                 drop_sum;
    logic                       fifo_wr, fifo_rd, chk_drop, din_drop;

    always_comb begin
        val_d = '0;
        for (int c = 0; c < NUM_CH; c++)
            val_d[c] = scale(raw_q[c*DATA_W +: DATA_W], CH_KIND[c]);
    end

    // Double-dabble step: add 3 to any digit >= 5, then shift one binary bit in.
    always_comb begin
        bcd_adj = '0;
        for (int k = 0; k < 4; k++)
            bcd_adj[4*k +: 4] = (bcd_q[4*k +: 4] >= 4'd5) ? bcd_q[4*k +: 4] + 4'd3 : bcd_q[4*k +: 4];
        bcd_nxt = 16'({bcd_adj, bin_q[10]});
    end

    assign ch_nxt    = ch_q + CW'(1);
    assign frame_len = mode_q ? IW'(BIN_LEN) : IW'(ASC_LEN);
    assign fifo_lvl  = wr_ptr_q - rd_ptr_q;
    assign free      = (AW+1)'(FIFO_DEPTH) - fifo_lvl;

    always_comb begin : build
        logic [IW-1:0] pos;
        logic [7:0]    xsum;
        frm  = '0;
        pos  = '0;
        xsum = 8'hA5 ^ 8'(NUM_CH);
        if (mode_q) begin
            frm[pos] = 8'hA5;       pos = pos + IW'(1);
            frm[pos] = 8'(NUM_CH);  pos = pos + IW'(1);
            for (int c = 0; c < NUM_CH; c++) begin
                frm[pos] = val_q[c][15:8]; pos = pos + IW'(1);
                frm[pos] = val_q[c][7:0];  pos = pos + IW'(1);
                xsum = xsum ^ val_q[c][15:8] ^ val_q[c][7:0];
            end
            frm[pos] = xsum;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (c > 0) begin
                    frm[pos] = 8'h09; pos = pos + IW'(1);
                end
                frm[pos] = CH_KIND[c] ? 8'h54 : 8'h48; pos = pos + IW'(1);
                frm[pos] = 8'h3A;                      pos = pos + IW'(1);
                if (CH_KIND[c]) begin
                    frm[pos] = val_q[c][15] ? 8'h2D : 8'h2B; pos = pos + IW'(1);
                end
                for (int k = 3; k >= 1; k--) begin
                    frm[pos] = {4'h3, dig_q[c][4*k +: 4]}; pos = pos + IW'(1);
                end
                frm[pos] = 8'h2E;                      pos = pos + IW'(1);
                frm[pos] = {4'h3, dig_q[c][3:0]};      pos = pos + IW'(1);
                frm[pos] = CH_KIND[c] ? 8'h43 : 8'h25; pos = pos + IW'(1);
            end
            frm[pos] = 8'h0D; pos = pos + IW'(1);
            frm[pos] = 8'h0A;
        end
    end

    always_comb begin
        state_d  = state_q;
        chk_drop = 1'b0;
        case (state_q)
            S_IDLE:  if (bus.din_vld) state_d = S_SCALE;
            S_SCALE: state_d = mode_q ? S_CHECK : S_CONV;
            S_CONV:  if (bit_q == 4'd10 && ch_q == CW'(NUM_CH - 1)) state_d = S_CHECK;
            S_CHECK: begin
                if (16'(free) >= 16'(frame_len)) begin
                    state_d = S_EMIT;
                end else begin
                    state_d  = S_IDLE;
                    chk_drop = 1'b1;
                end
            end
            S_EMIT:  if (idx_q == frame_len - IW'(1)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign din_drop = bus.din_vld && (state_q != S_IDLE);
    assign drop_sum = {1'b0, drop_q} + 9'(din_drop) + 9'(chk_drop);
    assign drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            drop_q  <= '0;
            raw_q   <= '0;
            mode_q  <= 1'b0;
            val_q   <= '0;
            dig_q   <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            bit_q   <= '0;
            ch_q    <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            case (state_q)
                S_IDLE: begin
                    if (bus.din_vld) begin
                        raw_q  <= bus.din;
                        mode_q <= bus.mode;
                    end
                end
                S_SCALE: begin
                    val_q <= val_d;
                    bin_q <= mag(val_d[0]);
                    bcd_q <= '0;
                    bit_q <= '0;
                    ch_q  <= '0;
                end
                S_CONV: begin
                    if (bit_q == 4'd10) begin
                        dig_q[ch_q] <= bcd_nxt;
                        bin_q       <= mag(val_q[ch_nxt]);
                        bcd_q       <= '0;
                        bit_q       <= '0;
                        ch_q        <= ch_nxt;
                    end else begin
                        bcd_q <= bcd_nxt;
                        bin_q <= {bin_q[9:0], 1'b0};
                        bit_q <= bit_q + 4'd1;
                    end
                end
                S_CHECK: idx_q <= '0;
                S_EMIT:  idx_q <= idx_q + IW'(1);
                default: ;
            endcase
        end
    end

    assign fifo_wr = (state_q == S_EMIT);
    assign fifo_rd = bus.tx_vld && bus.tx_rdy;

    always_ff @(posedge clk) begin
        if (fifo_wr) mem[wr_ptr_q[AW-1:0]] <= frm[idx_q];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (fifo_wr) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (fifo_rd) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    assign bus.tx_vld  = (fifo_lvl != '0);
    assign bus.tx_data = bus.tx_vld ? mem[rd_ptr_q[AW-1:0]] : 8'h00;
    assign busy        = (state_q != S_IDLE);
    assign drop_cnt    = drop_q;
endmodule

// File: tb/tb_sensor_frame_fmt.sv
// Scoreboard bench for sensor_frame_fmt: expected bytes come from literal frames or a behavioural model.
`timescale 1ns/1ps
module tb_sensor_frame_fmt;
    localparam int         NCH   = 2;
    localparam int         DW    = 20;
    localparam int         DEPTH = 64;
    localparam logic [1:0] KIND  = 2'b01;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       busy;
    logic [7:0] drop_cnt;
    logic [6:0] fifo_lvl;

    sensor_frame_fmt_if #(.NUM_CH(NCH), .DATA_W(DW)) bus ();

    sensor_frame_fmt #(
        .NUM_CH(NCH), .DATA_W(DW), .CH_KIND(KIND), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .busy(busy), .drop_cnt(drop_cnt), .fifo_lvl(fifo_lvl)
    );

    always #5 clk = ~clk;

    logic [7:0] exp_q[$];
    int vectors = 0, miscompares = 0, popped = 0;
    bit rnd_rdy = 1'b0;

    always @(negedge clk) begin : monitor
        logic [7:0] e;
        if (!rst && bus.tx_vld && bus.tx_rdy) begin
            vectors++;
            popped++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL tx_byte: got %02h, required no byte", bus.tx_data);
            end else begin
                e = exp_q.pop_front();
                if (bus.tx_data !== e) begin
                    miscompares++;
                    $display("FAIL tx_byte: got %02h, required %02h", bus.tx_data, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rnd_rdy) bus.tx_rdy = 1'($urandom_range(0, 1));
    endtask

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 2000) begin step(); n++; end
        if (busy) timeout("wait_idle");
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || bus.tx_vld) && n < 3000) begin step(); n++; end
        if (exp_q.size() != 0 || bus.tx_vld) timeout("wait_drain");
    endtask

    task automatic send(input logic [19:0] r0, input logic [19:0] r1, input logic m);
        bus.din     = {r1, r0};
        bus.mode    = m;
        bus.din_vld = 1'b1;
        step();
        bus.din_vld = 1'b0;
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic push_b(input logic [7:0] b);
        exp_q.push_back(b);
    endtask

    // Reference: values in tenths from plain integer arithmetic, then frame text/bytes.
    task automatic push_model(input logic [19:0] r0, input logic [19:0] r1, input logic m);
        int         v[2];
        int         a;
        longint     t;
        logic [7:0] x, hi, lo;
        logic [19:0] r[2];
        r[0] = r0;
        r[1] = r1;
        for (int c = 0; c < NCH; c++) begin
            t = r[c];
            if (KIND[c]) v[c] = int'(t * 2000 / (longint'(1) << DW)) - 500;
            else         v[c] = int'(t * 1000 / (longint'(1) << DW));
        end
        if (m) begin
            push_b(8'hA5);
            push_b(8'(NCH));
            x = 8'hA5 ^ 8'(NCH);
            for (int c = 0; c < NCH; c++) begin
                hi = 8'((v[c] >> 8) & 255);
                lo = 8'(v[c] & 255);
                push_b(hi);
                push_b(lo);
                x = x ^ hi ^ lo;
            end
            push_b(x);
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (c > 0) push_b(8'h09);
                push_b(KIND[c] ? 8'h54 : 8'h48);
                push_b(8'h3A);
                if (KIND[c]) push_b(v[c] < 0 ? 8'h2D : 8'h2B);
                a = (v[c] < 0) ? -v[c] : v[c];
                push_b(8'(48 + a / 1000));
                push_b(8'(48 + (a / 100) % 10));
                push_b(8'(48 + (a / 10) % 10));
                push_b(8'h2E);
                push_b(8'(48 + a % 10));
                push_b(KIND[c] ? 8'h43 : 8'h25);
            end
            push_b(8'h0D);
            push_b(8'h0A);
        end
    endtask

    function automatic logic [19:0] rnd20();
        return 20'($urandom_range(0, 20'hFFFFF));
    endfunction

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, n;
        logic [19:0] ra, rb;
        logic m;
        bus.din_vld = 1'b0;
        bus.din     = '0;
        bus.mode    = 1'b0;
        bus.tx_rdy  = 1'b0;

        rst = 1'b1;
        repeat (2) step();
        bus.din     = {20'h80000, 20'h66666};
        bus.din_vld = 1'b1;
        step();
        check("rst_tx_vld", int'(bus.tx_vld), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_drop_cnt", int'(drop_cnt), 0);
        check("rst_fifo_lvl", int'(fifo_lvl), 0);
        check("rst_tx_data", int'(bus.tx_data), 0);
        rst = 1'b0;
        bus.din_vld = 1'b0;
        step();
        check("din_vld_in_rst_ignored", int'(busy), 0);

        bus.tx_rdy = 1'b1;
        p0 = popped;
        push_str("T:+029.9C"); push_b(8'h09); push_str("H:050.0%"); push_b(8'h0D); push_b(8'h0A);
        send(20'h66666, 20'h80000, 1'b0);
        wait_idle();
        wait_drain();
        check("ascii_frame_len", popped - p0, 20);

        push_str("T:-050.0C"); push_b(8'h09); push_str("H:050.0%"); push_b(8'h0D); push_b(8'h0A);
        send(20'h00000, 20'h80000, 1'b0);
        wait_idle();
        wait_drain();

        p0 = popped;
        push_b(8'hA5); push_b(8'h02); push_b(8'h01); push_b(8'h2B); push_b(8'h01); push_b(8'hF4); push_b(8'h78);
        send(20'h66666, 20'h80000, 1'b1);
        wait_idle();
        wait_drain();
        check("bin_frame_len", popped - p0, 7);

        push_b(8'hA5); push_b(8'h02); push_b(8'hFE); push_b(8'h0C); push_b(8'h01); push_b(8'hF4); push_b(8'hA0);
        send(20'h00000, 20'h80000, 1'b1);
        wait_idle();
        wait_drain();

        bus.tx_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ra = rnd20();
            rb = rnd20();
            if (i < 3) push_model(ra, rb, 1'b0);
            send(ra, rb, 1'b0);
            wait_idle();
        end
        check("bp_fifo_lvl", int'(fifo_lvl), 60);
        check("bp_drop_cnt", int'(drop_cnt), 1);
        p0 = popped;
        bus.tx_rdy = 1'b1;
        wait_drain();
        check("bp_bytes_out", popped - p0, 60);
        check("bp_fifo_empty", int'(fifo_lvl), 0);

        ra = rnd20();
        rb = rnd20();
        push_model(ra, rb, 1'b0);
        send(ra, rb, 1'b0);
        step();
        send(~ra, ~rb, 1'b1);
        wait_idle();
        wait_drain();
        check("busy_drop_cnt", int'(drop_cnt), 2);

        bus.tx_rdy = 1'b0;
        send(rnd20(), rnd20(), 1'b0);
        n = 0;
        while (fifo_lvl != 7'd4 && n < 500) begin step(); n++; end
        if (fifo_lvl != 7'd4) timeout("wait_emit_byte5");
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        check("emit_rst_fifo_lvl", int'(fifo_lvl), 0);
        check("emit_rst_tx_vld", int'(bus.tx_vld), 0);
        check("emit_rst_busy", int'(busy), 0);
        check("emit_rst_drop_cnt", int'(drop_cnt), 0);
        bus.tx_rdy = 1'b1;
        p0 = popped;
        ra = rnd20();
        rb = rnd20();
        push_model(ra, rb, 1'b0);
        send(ra, rb, 1'b0);
        wait_idle();
        wait_drain();
        check("post_rst_frame_len", popped - p0, 20);

        rnd_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            n = 0;
            while ((busy || fifo_lvl > 7'd44) && n < 3000) begin step(); n++; end
            if (busy || fifo_lvl > 7'd44) timeout("wait_room");
            ra = (i == 0) ? 20'hFFFFF : (i == 1) ? 20'h00000 : rnd20();
            rb = (i == 0) ? 20'hFFFFF : (i == 1) ? 20'h00000 : rnd20();
            m  = (i < 2) ? 1'(i) : 1'($urandom_range(0, 1));
            push_model(ra, rb, m);
            send(ra, rb, m);
        end
        wait_idle();
        rnd_rdy = 1'b0;
        bus.tx_rdy = 1'b1;
        wait_drain();
        check("rand_drop_cnt", int'(drop_cnt), 0);
        check("rand_fifo_empty", int'(fifo_lvl), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sensor_frame_fmt.md
SENSOR_FRAME_FMT -- requirements
Module: sensor_frame_fmt

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of sensor channels, 1..4.
REQ-002 SHALL have parameter DATA_W, default 20: raw sample width per channel.
REQ-003 SHALL have parameter CH_KIND, default 2'b01, NUM_CH bits: bit i=1 means channel i is temperature; bit i=0 means humidity.
REQ-004 SHALL have parameter FIFO_DEPTH, default 64: output FIFO depth in bytes, power of 2, at least the longest frame.
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port din_vld, input, 1 bit: one-cycle sample strobe.
REQ-008 SHALL have port din, input, NUM_CH*DATA_W bits: raw samples, channel i at [i*DATA_W +: DATA_W].
REQ-009 SHALL have port mode, input, 1 bit: 0 selects ASCII frames, 1 selects binary frames; sampled with din_vld.
REQ-010 SHALL have port tx_data, output, 8 bits: FIFO head byte, first-word-fall-through.
REQ-011 SHALL have port tx_vld, output, 1 bit: high whenever the FIFO is not empty.
REQ-012 SHALL have port tx_rdy, input, 1 bit: UART ready; a byte transfers on clk when tx_vld and tx_rdy are both high.
REQ-013 SHALL have port busy, output, 1 bit: high whenever the FSM is not IDLE.
REQ-014 SHALL have port drop_cnt, output, 8 bits: saturating count of dropped samples.
REQ-015 SHALL have port fifo_lvl, output, log2(FIFO_DEPTH)+1 bits: FIFO occupancy.

Function
REQ-016 SHALL, on din_vld in IDLE, capture din and mode and enter SCALE.
- din_vld when not IDLE: sample dropped, drop_cnt +1, saturating at 255.
REQ-017 SHALL scale each channel exactly, with no intermediate truncation.
- Temperature: v = ((raw*2000)>>DATA_W) - 500, signed, units of 0.1 degC.
- Humidity: v = (raw*1000)>>DATA_W, units of 0.1 %.
REQ-018 SHALL run FSM states IDLE -> SCALE -> CONV -> CHECK -> EMIT -> IDLE.
- SCALE: 1 cycle for all channels.
- CONV: sequential binary-to-BCD of |v|, 4 digits per channel, in at most 16 cycles per channel; skipped in binary mode.
REQ-019 SHALL, in CHECK, compare FIFO free space against the frame length L.
- free >= L: go to EMIT.
- Otherwise: drop the whole frame, drop_cnt +1, return to IDLE; no partial frame is ever written.
REQ-020 SHALL, in EMIT, write one byte per cycle into the FIFO, then return to IDLE.
- EMIT never stalls, because CHECK guaranteed the space.
REQ-021 SHALL build the ASCII frame as follows.
- Channel fields in order 0..NUM_CH-1, separated by 0x09.
- Frame terminated by 0x0D 0x0A.
- Temperature field: 'T' ':' sign('-' if v<0, else '+') d2 d1 d0 '.' d_frac 'C'.
- Humidity field: 'H' ':' d2 d1 d0 '.' d_frac '%'.
- Digits are ASCII 0x30+n.
REQ-022 SHALL build the binary frame as follows.
- 0xA5, then NUM_CH.
- Per channel: v as 16-bit two's complement, MSB first.
- Final byte: XOR of all preceding frame bytes.
REQ-023 SHALL accept a FIFO write and read in the same cycle, leaving fifo_lvl unchanged.
REQ-024 SHALL ignore tx_rdy while the FIFO is empty; tx_data is then don't-care.
REQ-025 SHALL keep the byte stream contiguous per frame, with no interleaving between frames.

Reset
REQ-026 SHALL, while rst is high at a clk edge, set the following.
- FSM to IDLE; FIFO emptied.
- tx_vld=0, busy=0, drop_cnt=0, fifo_lvl=0, tx_data=0.
REQ-027 SHALL abort any frame under EMIT on rst.
- Its partially written bytes are discarded with the FIFO contents.
- First valid frame after reset starts with its header byte.
REQ-028 SHALL ignore din_vld in the cycle rst is high.

Verification
REQ-029 ASCII: NUM_CH=2, ch0 raw 0x66666, ch1 raw 0x80000, mode=0, tx_rdy=1 -> bytes "T:+029.9C" 09 "H:050.0%" 0D 0A (20 bytes).
REQ-030 Negative: ch0 raw 0x00000 -> field "T:-050.0C".
REQ-031 Binary: same samples as REQ-029, mode=1 -> A5 02 01 2B 01 F4 78.
- Ch0 raw 0 gives bytes FE 0C.
REQ-032 Back-pressure: tx_rdy=0, 4 ASCII samples spaced beyond EMIT, FIFO_DEPTH=64.
- 3 frames stored, fifo_lvl=60.
- 4th frame dropped, drop_cnt=1.
- Release tx_rdy -> exactly 60 bytes, frames intact.
REQ-033 Busy drop: second din_vld 2 cycles after the first -> drop_cnt=1, only the first frame is emitted.
REQ-034 Reset mid-EMIT: rst pulse on the 5th EMIT byte -> fifo_lvl=0, tx_vld=0; next sample yields a complete frame.
